// File: rtl/uart_transmit.sv
// UART transmitter: 8N1 framing, LSB first, one bit per CLOCK_DIVIDE clocks.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit before the stop bit.
// A new frame may be accepted in the last stop-bit cycle, so held requests stream
// back to back with no idle gap. tx_done still pulses in that case.
module uart_transmit #(
  parameter int unsigned CLOCK_DIVIDE = 1302
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       tx,
  output logic       is_transmitting,
  output logic       tx_done
);

  localparam logic [15:0] BitReload = 16'(CLOCK_DIVIDE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e      state_q;
  logic [15:0] count_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  // Frame sequencer: every output is a register so tx only moves at bit boundaries.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (transmit) begin
            state_q  <= StStart;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            shift_q  <= tx_byte;
            count_q  <= BitReload;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx_byte;
`endif
          end
        end

        StStart: begin
          if (count_q == 16'd0) begin
            state_q   <= StData;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= 3'd0;
            count_q   <= BitReload;
          end else begin
            count_q <= count_q - 16'd1;
          end
        end

        StData: begin
          if (count_q == 16'd0) begin
            count_q <= BitReload;
            // Index saturates at 7: the eighth bit always leaves the data state.
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
              tx_q    <= parity_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            count_q <= count_q - 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (count_q == 16'd0) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
            count_q <= BitReload;
          end else begin
            count_q <= count_q - 16'd1;
          end
        end
`endif

        StStop: begin
          if (count_q == 16'd0) begin
            done_q <= 1'b1;
            // Last stop cycle doubles as an accept slot for back-to-back frames.
            if (transmit) begin
              state_q  <= StStart;
              tx_q     <= 1'b0;
              shift_q  <= tx_byte;
              count_q  <= BitReload;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^tx_byte;
`endif
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end else begin
            count_q <= count_q - 16'd1;
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx              = tx_q;
  assign is_transmitting = busy_q;
  assign tx_done         = done_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit at CLOCK_DIVIDE=4: random and directed requests, a
// frame-level reference model, and a tx_done-driven scoreboard monitor.
module tb_uart_transmit;

  localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FLEN = FRAME * CD;

  logic       clock;
  logic       rst_n;
  logic [7:0] tx_byte;
  logic       transmit;
  logic       tx;
  logic       is_transmitting;
  logic       tx_done;

  uart_transmit #(.CLOCK_DIVIDE(CD)) dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .tx_byte        (tx_byte),
    .transmit       (transmit),
    .tx             (tx),
    .is_transmitting(is_transmitting),
    .tx_done        (tx_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    int         done_cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             e;
  logic             hist[$];
  int               rem = 0;
  int               cyc = 0;
  logic [FRAME-1:0] cur_bits = '1;
  int               vectors = 0;
  int               miscompares = 0;

  // Line waveform of one frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [FRAME-1:0] frame_bits(input logic [7:0] b);
    logic [FRAME-1:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = b[k];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: a frame occupies FLEN cycles; a request is taken when the line
  // is free or in the final cycle of the current frame.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      rem = 0;
    end else if ((rem == 0 || rem == 1) && transmit) begin
      cur_bits = frame_bits(tx_byte);
      rem      = FLEN;
      sb.push_back('{tx_byte, cyc + FLEN});
    end else if (rem != 0) begin
      rem = rem - 1;
    end
  end

  // Reset abandons the frame in flight and anything expected from it.
  always @(negedge rst_n) begin
    rem = 0;
    sb.delete();
  end

  // Monitor: per-cycle line check, and on tx_done pop and compare the finished frame.
  always @(negedge clock) begin
    logic exp_tx;
    logic [7:0] got;
    exp_tx = 1'b1;
    if (rem != 0) exp_tx = cur_bits[(FLEN - rem) / CD];
    check("tx", int'(tx), int'(exp_tx));
    check("is_transmitting", int'(is_transmitting), (rem != 0) ? 1 : 0);
    if (tx_done) begin
      if (sb.size() == 0) begin
        check("spurious_tx_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("tx_done_cycle", cyc, e.done_cyc);
        got = '0;
        if (hist.size() == FLEN) begin
          for (int k = 0; k < 8; k++) got[k] = hist[(k + 1) * CD + CD / 2];
        end
        check("frame_byte", int'(got), int'(e.b));
      end
    end else if (sb.size() != 0 && sb[0].done_cyc == cyc) begin
      check("missing_tx_done", 0, 1);
      void'(sb.pop_front());
    end
    hist.push_back(tx);
    if (hist.size() > FLEN) void'(hist.pop_front());
  end

  task automatic drive(input logic t, input logic [7:0] b);
    @(posedge clock);
    #2;
    transmit = t;
    tx_byte  = b;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, tx_byte);
  endtask

  initial begin
    rst_n    = 1'b0;
    transmit = 1'b0;
    tx_byte  = 8'h00;
    repeat (3) @(posedge clock);
    #2;
    rst_n = 1'b1;
    hold(3);
    check("reset_tx_idle", int'(tx), 1);

    // Single 0x55 frame from one request pulse.
    drive(1'b1, 8'h55);
    drive(1'b0, 8'h00);
    hold(FLEN + 8);

    // Request held high: streamed 0xA3 frames.
    drive(1'b1, 8'hA3);
    hold(0);
    for (int i = 0; i < 3 * FLEN; i++) drive(1'b1, 8'hA3);
    drive(1'b0, 8'h00);
    hold(FLEN + 8);

    // 0x0F, then a 0xFF request during data bit 3 must be ignored.
    drive(1'b1, 8'h0F);
    drive(1'b0, 8'h0F);
    hold(4 * CD);
    drive(1'b1, 8'hFF);
    drive(1'b0, 8'hFF);
    hold(FLEN);

    // 0xC3 aborted by reset during data bit 5; request held through reset.
    drive(1'b1, 8'hC3);
    drive(1'b0, 8'h00);
    hold(6 * CD);
    @(posedge clock);
    #2;
    rst_n    = 1'b0;
    transmit = 1'b1;
    tx_byte  = 8'h3C;
    #1;
    check("async_reset_tx", int'(tx), 1);
    check("async_reset_busy", int'(is_transmitting), 0);
    repeat (2) @(posedge clock);
    #2;
    rst_n = 1'b1;
    drive(1'b0, 8'h00);
    hold(FLEN + 8);

    // Randomized requests with bytes changing every cycle.
    for (int i = 0; i < 600; i++) begin
      if ((i / 100) % 2 == 1) drive($urandom_range(0, 3) != 0, 8'($urandom));
      else drive($urandom_range(0, 15) == 0, 8'($urandom));
    end

    drive(1'b0, 8'h00);
    hold(FLEN + 8);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
